// File: rtl/piso_feeder.sv
// rtl/piso_feeder.sv - FIFO-buffered pacing stage that feeds words and load strobes to a PISO serializer
//
// Buffers incoming words in a small circular FIFO and presents them one at a
// time to the serializer's parallel input. Each load strobe is followed by
// SHIFT_CYCLES quiet cycles so the serializer finishes shifting before the next
// word is latched. The output side has no ready input; pacing is the only
// output-side flow control.
//
// Ports
//   clk           clock, all logic on the rising edge
//   reset_n       asynchronous active-low reset
//   flush         synchronous clear of FIFO contents and the frame in progress
//   in_data       input word
//   in_valid      input word valid
//   in_ready      FIFO can accept a word (transfer = in_valid & in_ready)
//   parallel_out  word presented to the serializer parallel input
//   load          one-cycle load strobe to the serializer
//   busy          a frame (load + shift) is in progress
//   fifo_count    number of words currently buffered

module piso_feeder #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 4,
    parameter int SHIFT_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          parallel_out,
    output logic                       load,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SC_W  = (SHIFT_CYCLES > 1) ? $clog2(SHIFT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [SC_W-1:0]   shift_cnt;
    logic [SC_W-1:0]   shift_cnt_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;

    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [DATA_W-1:0] head;

    logic [DATA_W-1:0] parallel_out_nxt;
    logic              load_nxt;
    logic              busy_nxt;

    // in_ready looks only at the registered count, so a pop on a full FIFO
    // does not open a slot until the following cycle.
    assign in_ready   = (fifo_count < CNT_W'(DEPTH)) && !flush;
    assign push       = in_valid && in_ready;
    assign fifo_empty = (fifo_count == '0);

    // The head word leaves the FIFO on the edge that ends the LOAD cycle.
    assign pop = (state == S_LOAD) && !fifo_empty;

    // When the FIFO is empty but a word is arriving this edge (only possible
    // at the end of SHIFT), that incoming word is the one about to be loaded.
    assign head = fifo_empty ? in_data : mem[rd_ptr];

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            shift_cnt <= '0;
        end else begin
            state     <= state_nxt;
            shift_cnt <= shift_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        shift_cnt_nxt = shift_cnt;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    // Registered count only: a word pushed this edge is
                    // loaded one edge later.
                    if (!fifo_empty) begin
                        state_nxt = S_LOAD;
                    end
                end
                S_LOAD: begin
                    state_nxt     = S_SHIFT;
                    shift_cnt_nxt = SC_W'(SHIFT_CYCLES - 1);
                end
                S_SHIFT: begin
                    if (shift_cnt == '0) begin
                        // No pop happens in SHIFT, so the count after this
                        // edge is non-zero exactly when it is now or a push
                        // lands on this edge.
                        if (!fifo_empty || push) begin
                            state_nxt = S_LOAD;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        shift_cnt_nxt = shift_cnt - SC_W'(1);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        load_nxt         = (state_nxt == S_LOAD);
        busy_nxt         = (state_nxt != S_IDLE);
        parallel_out_nxt = parallel_out;
        // LOAD never repeats back-to-back, so entering it always means a new
        // word; parallel_out is then held through LOAD and SHIFT.
        if (load_nxt) begin
            parallel_out_nxt = head;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load         <= 1'b0;
            busy         <= 1'b0;
            parallel_out <= '0;
        end else begin
            load         <= load_nxt;
            busy         <= busy_nxt;
            parallel_out <= parallel_out_nxt;
        end
    end

endmodule
